// File: rtl/dmem_lsu_if.sv
// Word-wide D-Memory bus between the load/store unit (master) and a
// variable-latency memory (slave) using a req/ack handshake.
interface dmem_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: turns byte/half/word core accesses into word-aligned bus
// transactions and stalls the core until each completes.
// Optional posted-write buffer enabled by defining DMEM_LSU_STORE_BUFFER_EN.
module dmem_lsu #(
  parameter int TIMEOUT    = 255,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        addr_err_o,
  output logic        bus_err_o,
  dmem_lsu_if.master  bus
);

`ifdef DMEM_LSU_STORE_BUFFER_EN
  localparam bit PostedEn = 1'b1;
`else
  localparam bit PostedEn = 1'b0;
`endif

  localparam logic [9:0] ToLast = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        we_q, uns_q, posted_q, bus_err_q;
  logic [1:0]  size_q, lane_q;
  logic [9:0]  cnt_q;

  logic        req_any, misaligned, aligned_req, latch_en, timeout_hit;
  logic [1:0]  lane_sel;
  logic [3:0]  store_be;
  logic [31:0] store_wdata, ext_data;
  logic [7:0]  byte_w;
  logic [15:0] half_w;

  assign req_any     = mem_read_i | mem_write_i;
  assign misaligned  = (mem_size_i == 2'b01) ? addr_i[0]
                     : ((mem_size_i != 2'b00) && (addr_i[1:0] != 2'b00));
  assign aligned_req = req_any & ~misaligned;
  assign addr_err_o  = req_any & misaligned;
  // Lane 3 - a equals ~a for a two-bit lane index.
  assign lane_sel    = BIG_ENDIAN ? ~addr_i[1:0] : addr_i[1:0];

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = wdata_i;
    if (mem_write_i) begin
      case (mem_size_i)
        2'b00: begin
          store_be    = 4'b0001 << lane_sel;
          store_wdata = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          store_be    = lane_sel[1] ? 4'b1100 : 4'b0011;
          store_wdata = {2{wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_w = 8'(rdata_q >> {lane_q, 3'b000});
    half_w = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      2'b00:   ext_data = {{24{~uns_q & byte_w[7]}}, byte_w};
      2'b01:   ext_data = {{16{~uns_q & half_w[15]}}, half_w};
      default: ext_data = rdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    latch_en    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (aligned_req) begin
          latch_en = 1'b1;
          stall_o  = ~(PostedEn & mem_write_i);
          state_d  = BUS;
        end
      end
      BUS: begin
        stall_o = (PostedEn && posted_q) ? req_any : 1'b1;
        if (bus.ack) begin
          state_d = (PostedEn && posted_q) ? IDLE : RESP;
        end else if (cnt_q == ToLast) begin
          timeout_hit = 1'b1;
          state_d     = (PostedEn && posted_q) ? IDLE : RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      lane_q    <= '0;
      posted_q  <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= timeout_hit;
      if (latch_en) begin
        addr_q   <= {addr_i[31:2], 2'b00};
        wdata_q  <= store_wdata;
        be_q     <= store_be;
        we_q     <= mem_write_i;
        size_q   <= mem_size_i;
        uns_q    <= mem_unsigned_i;
        lane_q   <= lane_sel;
        posted_q <= PostedEn & mem_write_i;
      end
      if (state_q == BUS) begin
        if (bus.ack) begin
          cnt_q <= '0;
          if (!we_q) rdata_q <= bus.rdata;
        end else if (timeout_hit) begin
          cnt_q   <= '0;
          rdata_q <= '0;
        end else begin
          cnt_q <= cnt_q + 10'd1;
        end
      end
    end
  end

  assign bus.req     = (state_q == BUS);
  assign bus.we      = we_q;
  assign bus.addr    = addr_q;
  assign bus.wdata   = wdata_q;
  assign bus.be      = be_q;
  assign bus_err_o   = bus_err_q;
  assign read_data_o = (state_q == RESP) ? ext_data : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized and directed bench for dmem_lsu with a behavioural access model.
module tb_dmem_lsu;
  localparam int TO = 4;
  localparam bit BE = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] read_data;
  logic        stall, addr_err, bus_err;

  int          total = 0, bad = 0;
  int          resp_waits = 0;
  logic [31:0] resp_rdata = '0;

  dmem_lsu_if bus ();

  dmem_lsu #(.TIMEOUT(TO), .BIG_ENDIAN(BE)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_size_i(mem_size),
    .mem_unsigned_i(mem_unsigned), .addr_i(addr), .wdata_i(wdata),
    .read_data_o(read_data), .stall_o(stall), .addr_err_o(addr_err),
    .bus_err_o(bus_err), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Memory responder: ack after resp_waits wait cycles of an asserted request.
  initial begin : responder
    int wcnt;
    wcnt = 0;
    bus.ack = 1'b0;
    bus.rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.req) begin
        bus.ack   = (wcnt == resp_waits);
        bus.rdata = (wcnt == resp_waits) ? resp_rdata : $urandom;
        wcnt++;
      end else begin
        bus.ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Reference model: what the bus and core should see for one access.
  function automatic void model(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] brd, output logic mis, output logic [3:0] be,
                                output logic [31:0] wdo, output logic [31:0] rdv);
    int lane;
    logic [31:0] v;
    lane = BE ? 3 - int'(a % 4) : int'(a % 4);
    mis  = (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
    be = 4'hF;
    wdo = wd;
    if (wr && sz == 2'd0) begin
      be  = 4'(1 << lane);
      wdo = (wd & 32'hFF) * 32'h01010101;
    end else if (wr && sz == 2'd1) begin
      be  = (lane / 2 == 1) ? 4'hC : 4'h3;
      wdo = (wd & 32'hFFFF) * 32'h00010001;
    end
    if (sz == 2'd0) begin
      v = (brd >> (8 * lane)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (brd >> (16 * (lane / 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = brd;
    end
    rdv = rd ? v : 32'h0;
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    addr = a; wdata = wd;
  endtask

  // Holds one request until the core is released; for a posted store it also
  // follows the background bus cycle to completion with the core idle.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd,
                            output int stalls, output logic [31:0] rdv, output logic err,
                            output logic req_seen, output logic [31:0] oaddr,
                            output logic [31:0] owd, output logic [3:0] obe,
                            output logic owe, output logic aerr, output logic hung);
    stalls = 0; rdv = '0; err = 0; req_seen = 0; oaddr = '0; owd = '0;
    obe = '0; owe = 0; aerr = 0; hung = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      drive(rd, wr, sz, uns, a, wd);
      #1;
      if (bus.req) begin
        req_seen = 1; oaddr = bus.addr; owd = bus.wdata; obe = bus.be; owe = bus.we;
      end
      if (bus_err) err = 1;
      if (c == 0) aerr = addr_err;
      if (stall) stalls++;
      else begin
        rdv = read_data; hung = 0;
        break;
      end
    end
`ifdef DMEM_LSU_STORE_BUFFER_EN
    if (!hung && wr && !aerr) begin
      hung = 1;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
        #1;
        if (bus_err) err = 1;
        if (bus.req) begin
          req_seen = 1; oaddr = bus.addr; owd = bus.wdata; obe = bus.be; owe = bus.we;
        end else begin
          hung = 0;
          break;
        end
      end
    end
`endif
  endtask

  function automatic int exp_stalls(input logic wr, input logic mis, input int waits);
    if (mis) return 0;
`ifdef DMEM_LSU_STORE_BUFFER_EN
    if (wr) return 0;
`endif
    return 2 + waits;
  endfunction

  task automatic test_reset();
    drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus.req); end
    total++; if (bus.we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.we); end
    total++; if (bus.addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.addr); end
    total++; if (bus.wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.wdata); end
    total++; if (bus.be !== 4'h0) begin bad++; $display("FAIL reset_be got=%h exp=0", bus.be); end
    total++; if ({stall, bus_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {stall, bus_err}); end
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", read_data); end
    $display("reset: req=%b be=%h stall=%b", bus.req, bus.be, stall);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int st; logic [31:0] rv, oa, ow; logic er, rq, we, ae, hg; logic [3:0] ob;
    resp_waits = 0; resp_rdata = 32'hDEADBEEF;
    run_access(1, 0, 2'b10, 0, 32'h100, 32'h0, st, rv, er, rq, oa, ow, ob, we, ae, hg);
    $display("LW 0x100: stalls=%0d rdata=%h be=%h addr=%h", st, rv, ob, oa);
    total++; if (st !== 2 || hg) begin bad++; $display("FAIL lw_stalls got=%0d exp=2", st); end
    total++; if (rv !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", rv); end
    total++; if ({ob, oa} !== {4'hF, 32'h100}) begin bad++; $display("FAIL lw_bus got=%h/%h exp=f/100", ob, oa); end
    resp_rdata = 32'h80FFFFFF;
    run_access(1, 0, 2'b00, 0, 32'h103, 32'h0, st, rv, er, rq, oa, ow, ob, we, ae, hg);
    $display("LB 0x103: rdata=%h", rv);
    total++; if (rv !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", rv); end
    run_access(1, 0, 2'b00, 1, 32'h103, 32'h0, st, rv, er, rq, oa, ow, ob, we, ae, hg);
    $display("LBU 0x103: rdata=%h", rv);
    total++; if (rv !== 32'h00000080) begin bad++; $display("FAIL lbu_rdata got=%h exp=00000080", rv); end
    resp_rdata = 32'h8001AAAA;
    run_access(1, 0, 2'b01, 1, 32'h102, 32'h0, st, rv, er, rq, oa, ow, ob, we, ae, hg);
    $display("LHU 0x102: rdata=%h", rv);
    total++; if (rv !== 32'h00008001) begin bad++; $display("FAIL lhu_rdata got=%h exp=00008001", rv); end
    resp_waits = 3;
    run_access(0, 1, 2'b00, 0, 32'h201, 32'h000000A5, st, rv, er, rq, oa, ow, ob, we, ae, hg);
    $display("SB 0x201: stalls=%0d be=%h wdata=%h addr=%h we=%b", st, ob, ow, oa, we);
    total++; if ({ob, ow, oa, we} !== {4'b0010, 32'hA5A5A5A5, 32'h200, 1'b1} || hg) begin
      bad++; $display("FAIL sb_bus got=%h/%h/%h/%b exp=2/a5a5a5a5/200/1", ob, ow, oa, we); end
    total++; if (st !== exp_stalls(1, 0, 3)) begin bad++; $display("FAIL sb_stalls got=%0d exp=%0d", st, exp_stalls(1, 0, 3)); end
  endtask

  task automatic test_misaligned();
    int st; logic [31:0] rv, oa, ow; logic er, rq, we, ae, hg; logic [3:0] ob;
    resp_waits = 0;
    run_access(1, 0, 2'b10, 0, 32'h102, 32'h0, st, rv, er, rq, oa, ow, ob, we, ae, hg);
    $display("LW 0x102: addr_err=%b req=%b stalls=%0d rdata=%h", ae, rq, st, rv);
    total++; if ({ae, rq, rv} !== {1'b1, 1'b0, 32'h0} || st !== 0) begin
      bad++; $display("FAIL mis_lw got=%b/%b/%h/%0d exp=1/0/0/0", ae, rq, rv, st); end
    run_access(0, 1, 2'b01, 0, 32'h101, 32'h1234, st, rv, er, rq, oa, ow, ob, we, ae, hg);
    $display("SH 0x101: addr_err=%b req=%b stalls=%0d", ae, rq, st);
    total++; if ({ae, rq} !== 2'b10 || st !== 0) begin
      bad++; $display("FAIL mis_sh got=%b/%b/%0d exp=1/0/0", ae, rq, st); end
  endtask

  task automatic test_timeout();
    int st; logic [31:0] rv, oa, ow; logic er, rq, we, ae, hg; logic [3:0] ob;
    resp_waits = 1000;
    run_access(1, 0, 2'b10, 0, 32'h300, 32'h0, st, rv, er, rq, oa, ow, ob, we, ae, hg);
    $display("LW timeout: stalls=%0d bus_err=%b rdata=%h", st, er, rv);
    total++; if (st !== 1 + TO || hg) begin bad++; $display("FAIL to_stalls got=%0d exp=%0d", st, 1 + TO); end
    total++; if ({er, rv} !== {1'b1, 32'h0}) begin bad++; $display("FAIL to_err got=%b/%h exp=1/0", er, rv); end
    @(negedge clk);
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    #1;
    total++; if ({bus_err, bus.req, stall} !== 3'b000) begin
      bad++; $display("FAIL to_idle got=%b exp=000", {bus_err, bus.req, stall}); end
  endtask

  task automatic test_reset_midbus();
    int st; logic [31:0] rv, oa, ow; logic er, rq, we, ae, hg; logic [3:0] ob;
    resp_waits = 1000;
    repeat (3) begin
      @(negedge clk);
      drive(1, 0, 2'b10, 0, 32'h104, 32'h0);
    end
    #1;
    total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", bus.req); end
    #1 rst_n = 1'b0;
    #1;
    $display("reset mid-BUS: req=%b", bus.req);
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b exp=0", bus.req); end
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_waits = 1; resp_rdata = 32'h12345678;
    run_access(1, 0, 2'b10, 0, 32'h104, 32'h0, st, rv, er, rq, oa, ow, ob, we, ae, hg);
    $display("LW after reset: stalls=%0d rdata=%h", st, rv);
    total++; if (st !== 3 || rv !== 32'h12345678 || hg) begin
      bad++; $display("FAIL midrst_lw got=%0d/%h exp=3/12345678", st, rv); end
  endtask

  task automatic test_random();
    int st, w; logic [31:0] rv, oa, ow; logic er, rq, we, ae, hg; logic [3:0] ob;
    logic rd, wr, uns, mis; logic [1:0] sz; logic [31:0] a, wd, brd, ewd, erv; logic [3:0] ebe;
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom); wr = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
      a = 32'h1000 + ($urandom & 32'hFF); wd = $urandom; brd = $urandom;
      w = $urandom_range(0, 2);
      if (i % 8 == 7) begin rd = 0; wr = 0; end
      resp_waits = w; resp_rdata = brd;
      model(rd & ~wr, wr, sz, uns, a, wd, brd, mis, ebe, ewd, erv);
      mis = mis & (rd | wr);
      run_access(rd, wr, sz, uns, a, wd, st, rv, er, rq, oa, ow, ob, we, ae, hg);
      $display("rand %0d: rd=%b wr=%b sz=%0d a=%h stalls=%0d rdata=%h be=%h", i, rd, wr, sz, a, st, rv, ob);
      total++;
      if (hg || ae !== mis || er !== 1'b0) begin
        bad++; $display("FAIL rand_flags i=%0d got=%b/%b exp=%b/0", i, ae, er, mis);
      end else if (!(rd | wr) || mis) begin
        if (rq || st !== 0 || rv !== 32'h0) begin
          bad++; $display("FAIL rand_nobus i=%0d got=%b/%0d/%h exp=0/0/0", i, rq, st, rv); end
      end else if (st !== exp_stalls(wr, 0, w) || {oa, ob, we} !== {a & 32'hFFFFFFFC, ebe, wr}) begin
        bad++; $display("FAIL rand_bus i=%0d got=%0d/%h/%h/%b exp=%0d/%h/%h/%b",
                        i, st, oa, ob, we, exp_stalls(wr, 0, w), a & 32'hFFFFFFFC, ebe, wr);
      end else if (wr ? (ow !== ewd) : (rv !== erv)) begin
        bad++; $display("FAIL rand_data i=%0d got=%h/%h exp=%h/%h", i, ow, rv, ewd, erv);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sw_st, lw_st, w; logic [31:0] rv; logic done;
    w = 1; resp_waits = w; resp_rdata = 32'hCAFEF00D;
    sw_st = 0; lw_st = 0; rv = '0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk); drive(0, 1, 2'b10, 0, 32'h400, 32'h55AA55AA); #1;
      if (stall) sw_st++; else done = 1;
    end
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk); drive(1, 0, 2'b10, 0, 32'h404, 32'h0); #1;
      if (stall) lw_st++; else begin done = 1; rv = read_data; end
    end
    @(negedge clk); drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    $display("SW+LW: sw_stalls=%0d lw_stalls=%0d rdata=%h", sw_st, lw_st, rv);
`ifdef DMEM_LSU_STORE_BUFFER_EN
    total++; if (sw_st !== 0 || lw_st !== 2 * w + 3) begin
      bad++; $display("FAIL b2b_stalls got=%0d/%0d exp=0/%0d", sw_st, lw_st, 2 * w + 3); end
`else
    total++; if (sw_st !== 2 + w || lw_st !== 2 + w) begin
      bad++; $display("FAIL b2b_stalls got=%0d/%0d exp=%0d/%0d", sw_st, lw_st, 2 + w, 2 + w); end
`endif
    total++; if (!done || rv !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_rdata got=%h exp=cafef00d", rv); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_timeout();
    test_reset_midbus();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
